wb_packet_generator: RTL and testbench
======================================

// Module: wb_packet_generator
// PURPOSE
//  Producer side of the writeback-packet interface consumed by the register file.
//  - Stages even/odd pipe results by unit latency; emits one 143-bit packet per pipe per cycle.
//  - Resolves same-RT collisions between pipes: even writes first; odd is held one or more cycles and the odd pipe is stalled.
//  - Sits between the execute units and the register file; the register file never sees two same-cycle writes to one RT.
// PARAMETERS
//  DEPTH   7    staging stages per pipe; max unit latency
//  DATA_W  128  result width
//  ADDR_W  7    register address width
//  PKT_W   143  packet width
// PORTS
//  clock            in   1      single clock
//  reset            in   1      asynchronous, active-low
//  ep_res_valid     in   1      even-pipe result issued this cycle
//  ep_res_unit      in   3      unit id
//  ep_res_lat       in   3      latency 1..DEPTH (0 illegal, treated as 1)
//  ep_res_rt        in   7      destination register
//  ep_res_value     in   128    result value
//  op_res_valid/_unit/_lat/_rt/_value  in  1/3/3/7/128  odd-pipe equivalents
//  wrt_back_arr_ep  out  143    even writeback packet
//  wrt_back_arr_op  out  143    odd writeback packet
//  stall_odd        out  1      odd hold occupied; upstream freezes odd issue
//  lat_err_ep       out  1      one-cycle pulse: even slot conflict, new result dropped
//  lat_err_op       out  1      one-cycle pulse: odd slot conflict, new result dropped
// BEHAVIOUR
//  Packet format, bits [0:142]:
//   [0:2] unit; [3:130] value; [131] write enable; [132:138] RT; [139:141] latency; [142] 0.
//  Reset (reset==0, async): all stages, hold, outputs, stall_odd and lat_err_* go to 0.
//   Reset mid-operation discards in-flight results; nothing stale is emitted after release.
//  Staging per pipe: registers S[1..DEPTH]; each unfrozen edge shifts S[k] -> S[k+1].
//   A valid result with latency L is written into S[DEPTH-L+1] at the capture edge.
//   Output reflects S[DEPTH]; the packet is visible exactly L cycles after the input cycle, for one cycle.
//   An invalid S[DEPTH] drives an all-zero packet.
//  Slot conflict: target slot already receiving a valid shifted packet.
//   The older in-flight packet wins; the new one is dropped; lat_err_* pulses the next cycle.
//  Collision: S_ep[DEPTH] and S_op[DEPTH] both valid with equal RT.
//   Even emits normally; odd emits we=0 that cycle.
//   The odd packet moves into a 1-entry hold register (odd is younger, so it must write last).
//  While hold is valid:
//   - stall_odd=1, registered, asserted the cycle after the collision.
//   - The odd staging shift register freezes; op_res_* is ignored (upstream holds it).
//   - wrt_back_arr_op drives the hold packet with we=1, unless the hold RT equals a valid even output RT that cycle.
//     In that case it drives we=0 and keeps holding.
//   - On emit, hold clears at the edge; stall_odd deasserts the same edge and odd shifting resumes the next cycle.
//  Even pipe never stalls. Latency field is informational only.
// STRUCTURE
//  Package cellspu_wb_pkg:
//   - typedef packed struct wb_pkt_t (bit layout above).
//   - constants PKT_W, WE_BIT=131, RT_LSB/MSB, DEPTH.
//   - function pack_pkt().
//  Sub-module wb_stage_pipe (staging shift register with freeze and slot-conflict flag).
//   Instantiated once per pipe; collision and hold logic live in the top level.
// TESTING
//  1. ep lat=2 rt=5 val=0xAA..AA at t -> ep packet we=1 rt=5 at t+2 only; stall_odd=0.
//  2. ep lat=1 rt=9 and op lat=1 rt=9 at t:
//     - t+1: ep we=1 rt=9; op we=0.
//     - t+2: stall_odd=1; op we=1 rt=9 with odd value.
//     - t+3: stall_odd=0.
//  3. ep rt=3 and op rt=4, both lat=3, same cycle -> both we=1 at t+3; no stall.
//  4. ep lat=3 at t, then ep lat=2 at t+1 -> only the first packet is emitted (t+3); lat_err_ep pulses once.
//  5. Collision held while even writes rt=9 again the next cycle:
//     - hold persists; op we=0.
//     - stall_odd stays 1 until the cycle even's rt differs.
//  6. reset low with 4 packets in flight:
//     - outputs are zero immediately.
//     - after release, no packet is emitted for DEPTH cycles without new input.

Source files
------------

// File: rtl/wb_packet_generator_pkg.sv
// Shared types and constants for the writeback-packet generator.
// Packet layout (LSB first): unit, value, write enable, RT, latency, spare zero.
package cellspu_wb_pkg;

  localparam int DEPTH  = 7;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int UNIT_W = 3;
  localparam int LAT_W  = 3;
  localparam int PKT_W  = 143;
  localparam int WE_BIT = 131;
  localparam int RT_LSB = 132;
  localparam int RT_MSB = 138;

  typedef struct packed {
    logic              pad;
    logic [LAT_W-1:0]  lat;
    logic [ADDR_W-1:0] rt;
    logic              we;
    logic [DATA_W-1:0] value;
    logic [UNIT_W-1:0] unit;
  } wb_pkt_t;

  function automatic logic [LAT_W-1:0] norm_lat(input logic [LAT_W-1:0] lat);
    if (lat == 3'd0) begin
      return 3'd1;
    end else begin
      return lat;
    end
  endfunction

  function automatic wb_pkt_t pack_pkt(input logic [UNIT_W-1:0] unit,
                                       input logic [DATA_W-1:0] value,
                                       input logic [ADDR_W-1:0] rt,
                                       input logic [LAT_W-1:0]  lat);
    wb_pkt_t pkt;
    pkt       = '0;
    pkt.unit  = unit;
    pkt.value = value;
    pkt.we    = 1'b1;
    pkt.rt    = rt;
    pkt.lat   = norm_lat(lat);
    pkt.pad   = 1'b0;
    return pkt;
  endfunction

endpackage

// File: rtl/wb_packet_generator_stage.sv
// Per-pipe latency staging shift register with freeze and slot-conflict detection.
// Invalid stages are kept all-zero so the head can be emitted directly.
module wb_stage_pipe
  import cellspu_wb_pkg::*;
#(
  parameter int STAGES = DEPTH
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    freeze,
  input  logic    in_valid,
  input  wb_pkt_t in_pkt,
  output wb_pkt_t out_pkt,
  output logic    lat_err
);

  localparam int IDX_W = $clog2(STAGES + 1) + 1;

  wb_pkt_t          stage_r [1:STAGES];
  logic [IDX_W-1:0] tgt_s;
  logic             conflict_s;
  logic             capture_s;

  // Target slot and whether an older packet is shifting into it this edge.
  always_comb begin
    tgt_s      = IDX_W'(STAGES) - IDX_W'(in_pkt.lat) + IDX_W'(1);
    conflict_s = 1'b0;
    for (int k = 2; k <= STAGES; k++) begin
      conflict_s = conflict_s | ((tgt_s == IDX_W'(k)) & stage_r[k-1].we);
    end
    capture_s = in_valid & ~conflict_s;
  end

  // Shift/capture unless frozen; conflict flag pulses for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        stage_r[k] <= '0;
      end
      lat_err <= 1'b0;
    end else if (freeze) begin
      lat_err <= 1'b0;
    end else begin
      if (capture_s && (tgt_s == IDX_W'(1))) begin
        stage_r[1] <= in_pkt;
      end else begin
        stage_r[1] <= '0;
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (capture_s && (tgt_s == IDX_W'(k))) begin
          stage_r[k] <= in_pkt;
        end else begin
          stage_r[k] <= stage_r[k-1];
        end
      end
      lat_err <= in_valid & conflict_s;
    end
  end

  assign out_pkt = stage_r[STAGES];

endmodule

// File: rtl/wb_packet_generator.sv
// Writeback packet producer: stages even/odd results by latency and serialises
// same-RT collisions so the register file never sees two writes to one RT.
module wb_packet_generator
  import cellspu_wb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ep_res_valid,
  input  logic [UNIT_W-1:0] ep_res_unit,
  input  logic [LAT_W-1:0]  ep_res_lat,
  input  logic [ADDR_W-1:0] ep_res_rt,
  input  logic [DATA_W-1:0] ep_res_value,
  input  logic              op_res_valid,
  input  logic [UNIT_W-1:0] op_res_unit,
  input  logic [LAT_W-1:0]  op_res_lat,
  input  logic [ADDR_W-1:0] op_res_rt,
  input  logic [DATA_W-1:0] op_res_value,
  output logic [PKT_W-1:0]  wrt_back_arr_ep,
  output logic [PKT_W-1:0]  wrt_back_arr_op,
  output logic              stall_odd,
  output logic              lat_err_ep,
  output logic              lat_err_op
);

  wb_pkt_t ep_in_s;
  wb_pkt_t op_in_s;
  wb_pkt_t ep_head_s;
  wb_pkt_t op_head_s;
  wb_pkt_t op_out_s;
  wb_pkt_t hold_r;
  logic    hold_valid_s;
  logic    op_capture_s;
  logic    collide_s;
  logic    hold_block_s;

  assign ep_in_s      = pack_pkt(ep_res_unit, ep_res_value, ep_res_rt, ep_res_lat);
  assign op_in_s      = pack_pkt(op_res_unit, op_res_value, op_res_rt, op_res_lat);
  assign hold_valid_s = hold_r[WE_BIT];
  assign op_capture_s = op_res_valid & ~hold_valid_s;

  wb_stage_pipe #(.STAGES(DEPTH)) u_ep_pipe (
    .clock    (clock),
    .reset    (reset),
    .freeze   (1'b0),
    .in_valid (ep_res_valid),
    .in_pkt   (ep_in_s),
    .out_pkt  (ep_head_s),
    .lat_err  (lat_err_ep)
  );

  // Odd pipe freezes while the hold register owns the odd writeback slot.
  wb_stage_pipe #(.STAGES(DEPTH)) u_op_pipe (
    .clock    (clock),
    .reset    (reset),
    .freeze   (hold_valid_s),
    .in_valid (op_capture_s),
    .in_pkt   (op_in_s),
    .out_pkt  (op_head_s),
    .lat_err  (lat_err_op)
  );

  // Odd output select: held packet, collision-suppressed head, or plain head.
  always_comb begin
    collide_s    = 1'b0;
    hold_block_s = 1'b0;
    op_out_s     = op_head_s;
    if (hold_valid_s) begin
      hold_block_s = ep_head_s[WE_BIT] &
                     (ep_head_s[RT_MSB:RT_LSB] == hold_r[RT_MSB:RT_LSB]);
      op_out_s     = hold_r;
      op_out_s.we  = ~hold_block_s;
    end else begin
      collide_s   = ep_head_s[WE_BIT] & op_head_s[WE_BIT] &
                    (ep_head_s[RT_MSB:RT_LSB] == op_head_s[RT_MSB:RT_LSB]);
      op_out_s.we = op_head_s.we & ~collide_s;
    end
  end

  // Hold register: capture odd packet on collision, release once it can write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_r <= '0;
    end else if (hold_valid_s) begin
      if (hold_block_s) begin
        hold_r <= hold_r;
      end else begin
        hold_r <= '0;
      end
    end else if (collide_s) begin
      hold_r <= op_head_s;
    end else begin
      hold_r <= '0;
    end
  end

  assign wrt_back_arr_ep = ep_head_s;
  assign wrt_back_arr_op = op_out_s;
  assign stall_odd       = hold_valid_s;

endmodule

// File: tb/tb_wb_packet_generator.sv
// Self-checking bench: directed scenarios plus random traffic against a
// schedule-based reference model (results keyed by their due cycle).
module tb_wb_packet_generator;

  localparam int DEPTH = 7;

  logic         clock = 1'b0;
  logic         reset;
  logic         ep_res_valid, op_res_valid;
  logic [2:0]   ep_res_unit, ep_res_lat, op_res_unit, op_res_lat;
  logic [6:0]   ep_res_rt, op_res_rt;
  logic [127:0] ep_res_value, op_res_value;
  logic [142:0] wrt_back_arr_ep, wrt_back_arr_op;
  logic         stall_odd, lat_err_ep, lat_err_op;

  always #5 clock = ~clock;

  wb_packet_generator dut (
    .clock           (clock),
    .reset           (reset),
    .ep_res_valid    (ep_res_valid),
    .ep_res_unit     (ep_res_unit),
    .ep_res_lat      (ep_res_lat),
    .ep_res_rt       (ep_res_rt),
    .ep_res_value    (ep_res_value),
    .op_res_valid    (op_res_valid),
    .op_res_unit     (op_res_unit),
    .op_res_lat      (op_res_lat),
    .op_res_rt       (op_res_rt),
    .op_res_value    (op_res_value),
    .wrt_back_arr_ep (wrt_back_arr_ep),
    .wrt_back_arr_op (wrt_back_arr_op),
    .stall_odd       (stall_odd),
    .lat_err_ep      (lat_err_ep),
    .lat_err_op      (lat_err_op)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: packets keyed by the (unfrozen) tick they are due.
  logic [142:0] ep_sched [int];
  logic [142:0] op_sched [int];
  int           ep_tick = 0;
  int           op_tick = 0;
  logic         hold_v  = 1'b0;
  logic [142:0] hold_m  = '0;
  logic         err_ep_m = 1'b0;
  logic         err_op_m = 1'b0;

  task automatic chk(input string tag, input logic [142:0] act, input logic [142:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [142:0] mk_pkt(input logic [2:0] unit, input logic [127:0] value,
                                          input logic [6:0] rt, input logic [2:0] lat);
    logic [2:0] l;
    l = (lat == 3'd0) ? 3'd1 : lat;
    return {1'b0, l, rt, 1'b1, value, unit};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_ep(input logic v, input logic [2:0] lat, input logic [6:0] rt, input logic [127:0] val);
    ep_res_valid = v; ep_res_lat = lat; ep_res_rt = rt; ep_res_value = val;
    ep_res_unit  = 3'($urandom_range(0, 7));
  endtask

  task automatic set_op(input logic v, input logic [2:0] lat, input logic [6:0] rt, input logic [127:0] val);
    op_res_valid = v; op_res_lat = lat; op_res_rt = rt; op_res_value = val;
    op_res_unit  = 3'($urandom_range(0, 7));
  endtask

  task automatic idle();
    set_ep(1'b0, 3'd0, 7'd0, 128'd0);
    set_op(1'b0, 3'd0, 7'd0, 128'd0);
  endtask

  // One cycle: predict, check at negedge, then advance the model at posedge.
  task automatic step();
    logic [142:0] ep_exp, op_head;
    logic         blocked, collide;
    logic [2:0]   l;
    int           key;
    ep_exp  = ep_sched.exists(ep_tick) ? ep_sched[ep_tick] : 143'd0;
    op_head = op_sched.exists(op_tick) ? op_sched[op_tick] : 143'd0;
    blocked = hold_v && ep_exp[131] && (ep_exp[138:132] == hold_m[138:132]);
    collide = !hold_v && ep_exp[131] && op_head[131] && (ep_exp[138:132] == op_head[138:132]);
    @(negedge clock);
    chk("ep_pkt", wrt_back_arr_ep, ep_exp);
    if (hold_v && !blocked)
      chk("op_hold_pkt", wrt_back_arr_op, hold_m);
    else if (hold_v || collide)
      chk("op_we_suppressed", 143'(wrt_back_arr_op[131]), 143'd0);
    else
      chk("op_pkt", wrt_back_arr_op, op_head);
    chk("stall_odd", 143'(stall_odd), 143'(hold_v));
    chk("lat_err_ep", 143'(lat_err_ep), 143'(err_ep_m));
    chk("lat_err_op", 143'(lat_err_op), 143'(err_op_m));
    @(posedge clock);
    ep_sched.delete(ep_tick);
    err_ep_m = 1'b0;
    if (ep_res_valid) begin
      l   = (ep_res_lat == 3'd0) ? 3'd1 : ep_res_lat;
      key = ep_tick + int'(l);
      if (ep_sched.exists(key)) err_ep_m = 1'b1;
      else ep_sched[key] = mk_pkt(ep_res_unit, ep_res_value, ep_res_rt, ep_res_lat);
    end
    ep_tick++;
    err_op_m = 1'b0;
    if (hold_v) begin
      if (!blocked) begin
        hold_v = 1'b0;
        hold_m = '0;
      end
    end else begin
      if (collide) begin
        hold_v = 1'b1;
        hold_m = op_head;
      end
      op_sched.delete(op_tick);
      if (op_res_valid) begin
        l   = (op_res_lat == 3'd0) ? 3'd1 : op_res_lat;
        key = op_tick + int'(l);
        if (op_sched.exists(key)) err_op_m = 1'b1;
        else op_sched[key] = mk_pkt(op_res_unit, op_res_value, op_res_rt, op_res_lat);
      end
      op_tick++;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #1;
    chk("rst_ep_pkt", wrt_back_arr_ep, 143'd0);
    chk("rst_op_pkt", wrt_back_arr_op, 143'd0);
    chk("rst_stall", 143'(stall_odd), 143'd0);
    chk("rst_err_ep", 143'(lat_err_ep), 143'd0);
    chk("rst_err_op", 143'(lat_err_op), 143'd0);
    ep_sched.delete();
    op_sched.delete();
    hold_v = 1'b0; hold_m = '0; err_ep_m = 1'b0; err_op_m = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #2;
    chk("init_ep_pkt", wrt_back_arr_ep, 143'd0);
    chk("init_op_pkt", wrt_back_arr_op, 143'd0);
    chk("init_stall", 143'(stall_odd), 143'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Single even result, latency 2.
    set_ep(1'b1, 3'd2, 7'd5, {4{32'hAAAA_AAAA}}); step(); idle();
    repeat (4) step();
    // Same-RT collision, latency 1 on both pipes.
    set_ep(1'b1, 3'd1, 7'd9, rnd128()); set_op(1'b1, 3'd1, 7'd9, rnd128()); step(); idle();
    repeat (4) step();
    // Different RTs, same latency: no stall.
    set_ep(1'b1, 3'd3, 7'd3, rnd128()); set_op(1'b1, 3'd3, 7'd4, rnd128()); step(); idle();
    repeat (5) step();
    // Even slot conflict: the older packet wins.
    set_ep(1'b1, 3'd3, 7'd6, rnd128()); step();
    set_ep(1'b1, 3'd2, 7'd7, rnd128()); step(); idle();
    repeat (5) step();
    // Collision with the hold blocked by a second even write to the same RT.
    set_ep(1'b1, 3'd1, 7'd9, rnd128()); set_op(1'b1, 3'd1, 7'd9, rnd128()); step();
    set_ep(1'b1, 3'd1, 7'd9, rnd128()); set_op(1'b0, 3'd0, 7'd0, 128'd0); step(); idle();
    repeat (5) step();
    // Latency 0 is treated as 1.
    set_ep(1'b1, 3'd0, 7'd2, rnd128()); step(); idle();
    repeat (3) step();
    // Reset with four packets in flight, then an idle window.
    set_ep(1'b1, 3'd7, 7'd1, rnd128()); set_op(1'b1, 3'd7, 7'd2, rnd128()); step();
    set_ep(1'b1, 3'd7, 7'd3, rnd128()); set_op(1'b1, 3'd7, 7'd4, rnd128()); step();
    do_reset();
    repeat (DEPTH + 2) step();

    // Random traffic with small RT space to provoke collisions and conflicts.
    for (int c = 0; c < 3000; c++) begin
      set_ep(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 3)), rnd128());
      set_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 3)), rnd128());
      if (c == 1500) do_reset();
      else step();
    end
    idle();
    repeat (DEPTH + 6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
